pacman_dir_ctrl: RTL and testbench

//  Direction-command stage directly downstream of the four per-button debouncers.

---
 rtl/pacman_dir_ctrl.sv | 127 ++++++++++++
 tb/tb_pacman_dir_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_dir_ctrl.sv
// Direction-command stage: synchronises debounced clicks, detects presses, adds
// auto-repeat while a button is held and keeps one pending command until acknowledged.
module pacman_dir_ctrl #(
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 100,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1ms,
    input  logic       click_up,
    input  logic       click_down,
    input  logic       click_left,
    input  logic       click_right,
    input  logic       dir_ack,
    output logic       dir_valid,
    output logic [1:0] dir_code,
    output logic [1:0] cur_dir,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    // Bit index equals the direction code: 0=UP 1=DOWN 2=LEFT 3=RIGHT.
    logic [3:0] click;
    logic [3:0] sync1;
    logic [3:0] sync;
    logic [3:0] prev;
    logic [3:0] rise;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       held_dir;

    logic       press;
    logic [1:0] press_dir;
    logic       released;
    logic       rep_event;
    logic       ev;
    logic [1:0] ev_code;

    assign click = {click_right, click_left, click_down, click_up};
    assign rise  = sync & ~prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync  <= '0;
            prev  <= '0;
        end else begin
            sync1 <= click;
            sync  <= sync1;
            prev  <= sync;
        end
    end

    always_comb begin
        press     = |rise;
        press_dir = 2'd3;
        if (rise[0])      press_dir = 2'd0;
        else if (rise[1]) press_dir = 2'd1;
        else if (rise[2]) press_dir = 2'd2;
        released  = (state != IDLE) && !sync[held_dir];
        rep_event = 1'b0;
        if (!released && tick_1ms) begin
            if (state == DELAY && cnt == DELAY_LAST)   rep_event = 1'b1;
            if (state == REPEAT && cnt == RATE_LAST)   rep_event = 1'b1;
        end
        ev      = press | rep_event;
        ev_code = press ? press_dir : held_dir;
    end

    // A new press always restarts the delay, whatever the repeat state was doing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            held_dir <= 2'd0;
        end else if (press) begin
            state    <= DELAY;
            cnt      <= '0;
            held_dir <= press_dir;
        end else begin
            case (state)
                DELAY, REPEAT: begin
                    if (released) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (tick_1ms) begin
                        if (rep_event) begin
                            state <= REPEAT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // One-entry pending slot; an event in the same clk as an ack refills it silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_valid <= 1'b0;
            dir_code  <= 2'd0;
            cur_dir   <= 2'd2;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (ev) begin
                dir_valid <= 1'b1;
                dir_code  <= ev_code;
                overrun   <= dir_valid & ~dir_ack;
            end else if (dir_ack) begin
                dir_valid <= 1'b0;
            end
            if (dir_ack && dir_valid) cur_dir <= dir_code;
        end
    end
endmodule

// File: tb/tb_pacman_dir_ctrl.sv
// Bench for pacman_dir_ctrl: directed presses, a queue of expected command codes
// checked at each acknowledge handshake, plus direct checks of timing and status.
module tb_pacman_dir_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1ms = 1'b0;
    logic       click_up = 1'b0;
    logic       click_down = 1'b0;
    logic       click_left = 1'b0;
    logic       click_right = 1'b0;
    logic       dir_ack = 1'b0;
    logic       dir_valid;
    logic [1:0] dir_code;
    logic [1:0] cur_dir;
    logic       overrun;

    int         total = 0;
    int         bad = 0;
    logic [1:0] exp_q[$];
    int         ack_ticks[$];
    int         tick_cnt = 0;
    int         acc_cnt = 0;
    int         ov_cnt = 0;
    bit         auto_ack = 1'b0;
    logic [1:0] mon_exp;

    pacman_dir_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1ms   (tick_1ms),
        .click_up   (click_up),
        .click_down (click_down),
        .click_left (click_left),
        .click_right(click_right),
        .dir_ack    (dir_ack),
        .dir_valid  (dir_valid),
        .dir_code   (dir_code),
        .cur_dir    (cur_dir),
        .overrun    (overrun)
    );

    // clock / reset-independent strobes
    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #1 tick_1ms = 1'b1;
            tick_cnt++;
            @(posedge clk);
            #1 tick_1ms = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack) dir_ack = dir_valid && !dir_ack;
        end
    end

    // monitor: every accepted command is matched against the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (overrun === 1'b1) ov_cnt++;
            if (dir_valid === 1'b1 && dir_ack === 1'b1) begin
                acc_cnt++;
                ack_ticks.push_back(tick_cnt);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd: got code %0d, expected no command", dir_code);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("cmd_code", 32'(dir_code), 32'(mon_exp));
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        dir_ack = 1'b1;
        cyc(1);
        dir_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"},   32'(dir_valid), 0);
        check({tag, "_code"},    32'(dir_code),  0);
        check({tag, "_cur_dir"}, 32'(cur_dir),   2);
        check({tag, "_overrun"}, 32'(overrun),   0);
    endtask

    initial begin
        int ov0;
        int t_start;
        int b;
        int a0;

        // reset
        cyc(4);
        check_reset_vals("reset");
        rst_n = 1'b1;
        cyc(3);

        // single LEFT press: three-edge latency, then ack
        click_left = 1'b1;
        exp_q.push_back(2'd2);
        cyc(2);
        check("left_lat2_valid", 32'(dir_valid), 0);
        cyc(1);
        check("left_lat3_valid", 32'(dir_valid), 1);
        check("left_code", 32'(dir_code), 2);
        cyc(47);
        click_left = 1'b0;
        cyc(3);
        do_ack();
        check("left_ack_valid", 32'(dir_valid), 0);
        check("left_cur_dir", 32'(cur_dir), 2);
        cyc(5);

        // UP and RIGHT rise together: UP wins, RIGHT is dropped
        click_up = 1'b1;
        click_right = 1'b1;
        exp_q.push_back(2'd0);
        cyc(8);
        check("simul_valid", 32'(dir_valid), 1);
        check("simul_code", 32'(dir_code), 0);
        do_ack();
        cyc(10);
        check("simul_no_second", 32'(dir_valid), 0);
        check("simul_cur_dir", 32'(cur_dir), 0);
        click_up = 1'b0;
        click_right = 1'b0;
        cyc(5);

        // UP then RIGHT without ack: overwrite and one overrun pulse
        ov0 = ov_cnt;
        click_up = 1'b1;
        cyc(6);
        check("ovr_first_code", 32'(dir_code), 0);
        click_up = 1'b0;
        cyc(3);
        click_right = 1'b1;
        exp_q.push_back(2'd3);
        cyc(6);
        check("ovr_valid", 32'(dir_valid), 1);
        check("ovr_code", 32'(dir_code), 3);
        check("ovr_pulses", 32'(ov_cnt - ov0), 1);
        do_ack();
        check("ovr_cur_dir", 32'(cur_dir), 3);
        check("ovr_ack_valid", 32'(dir_valid), 0);
        click_right = 1'b0;
        cyc(5);

        // event in the same clk as ack
        click_down = 1'b1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        cyc(5);
        check("coinc_first_code", 32'(dir_code), 1);
        click_down = 1'b0;
        cyc(3);
        ov0 = ov_cnt;
        click_left = 1'b1;
        cyc(2);
        dir_ack = 1'b1;
        cyc(1);
        dir_ack = 1'b0;
        check("coinc_cur_dir", 32'(cur_dir), 1);
        check("coinc_code", 32'(dir_code), 2);
        check("coinc_valid", 32'(dir_valid), 1);
        cyc(2);
        check("coinc_no_overrun", 32'(ov_cnt - ov0), 0);
        do_ack();
        click_left = 1'b0;
        check("coinc_cur_dir2", 32'(cur_dir), 2);
        cyc(5);

        // hold DOWN for 500 ticks with every command acknowledged
        b = ack_ticks.size();
        a0 = acc_cnt;
        repeat (4) exp_q.push_back(2'd1);
        auto_ack = 1'b1;
        click_down = 1'b1;
        t_start = tick_cnt;
        while (tick_cnt - t_start < 500) cyc(1);
        click_down = 1'b0;
        cyc(30);
        auto_ack = 1'b0;
        cyc(1);
        dir_ack = 1'b0;
        check("hold_cmd_count", 32'(acc_cnt - a0), 4);
        if (acc_cnt - a0 == 4) begin
            check("hold_first_at0", 32'(ack_ticks[b] - t_start <= 1), 1);
            check("hold_delay_250",
                  32'(ack_ticks[b+1] - ack_ticks[b] >= 249 && ack_ticks[b+1] - ack_ticks[b] <= 251), 1);
            check("hold_rate_100a",
                  32'(ack_ticks[b+2] - ack_ticks[b+1] >= 99 && ack_ticks[b+2] - ack_ticks[b+1] <= 101), 1);
            check("hold_rate_100b",
                  32'(ack_ticks[b+3] - ack_ticks[b+2] >= 99 && ack_ticks[b+3] - ack_ticks[b+2] <= 101), 1);
        end
        check("hold_idle_valid", 32'(dir_valid), 0);
        cyc(5);

        // reset while auto-repeating with RIGHT held
        click_right = 1'b1;
        exp_q.push_back(2'd3);
        t_start = tick_cnt;
        cyc(5);
        do_ack();
        check("rst_pre_cur_dir", 32'(cur_dir), 3);
        while (tick_cnt - t_start < 260) cyc(1);
        check("rst_pre_valid", 32'(dir_valid), 1);
        rst_n = 1'b0;
        cyc(2);
        check_reset_vals("midrst");
        exp_q.push_back(2'd3);
        rst_n = 1'b1;
        cyc(2);
        check("rst_lat2_valid", 32'(dir_valid), 0);
        cyc(1);
        check("rst_lat3_valid", 32'(dir_valid), 1);
        check("rst_code", 32'(dir_code), 3);
        do_ack();
        click_right = 1'b0;
        check("rst_cur_dir", 32'(cur_dir), 3);
        cyc(10);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
